// File: rtl/mips_bus_ram_waitstate_if.sv
// Avalon-style CPU data bus between mips_cpu_bus and a memory slave.
// The master drives the request signals; the slave answers with waitrequest and readdata.
interface mips_bus_ram_waitstate_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_ram_waitstate.sv
// 4096x32 byte-enabled RAM slave that inserts fixed or LFSR-driven wait states
// per transaction, so that the CPU's stall handling gets exercised.
module mips_bus_ram_waitstate #(
  parameter string       RAM_INIT_FILE = "",
  parameter int          WAIT_CYCLES   = 2,
  parameter bit          RANDOM_WAIT   = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_bus_ram_waitstate_if.slave       bus,
  output logic                          protocol_error,
  output logic [15:0]                   txn_count
);

  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d, wait_val;
  logic [15:0] lfsr;
  logic        req, rw_both, misaligned, accept, drop;
  logic [11:0] idx;
  logic [31:0] rdata_p1;
  logic [31:0] mem [0:4095];
  logic        unused_addr_hi;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign req            = bus.read | bus.write;
  assign rw_both        = bus.read & bus.write;
  assign misaligned     = bus.address[1:0] != 2'b00;
  assign idx            = bus.address[13:2];
  assign unused_addr_hi = ^bus.address[31:14];
  assign bus.readdata   = rdata_p1;

  always_comb begin
    if (RANDOM_WAIT) wait_val = 4'(32'(lfsr[3:0]) % (WAIT_CYCLES + 1));
    else             wait_val = 4'(WAIT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // The IDLE cycle that sees the request is itself the first stall cycle,
  // so cnt holds the stall cycles still to come after it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (req && !rw_both && wait_val != 4'd0) begin
          cnt_d   = wait_val - 4'd1;
          state_d = (wait_val == 4'd1) ? ACCEPT : STALL;
        end
      end
      STALL: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_d = ACCEPT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ACCEPT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.waitrequest = 1'b0;
    accept          = 1'b0;
    drop            = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (rw_both || wait_val == 4'd0) accept = 1'b1;
            else                             bus.waitrequest = 1'b1;
          end
        end
        STALL: begin
          bus.waitrequest = 1'b1;
          drop            = !req;
        end
        ACCEPT: begin
          accept = req;
          drop   = !req;
        end
        default: ;
      endcase
    end
  end

  // Accept edge: bookkeeping and registered read data (valid the cycle after)
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1       <= 32'd0;
      protocol_error <= 1'b0;
      txn_count      <= 16'd0;
      lfsr           <= LFSR_SEED;
    end else begin
      if (accept) begin
        txn_count <= txn_count + 16'd1;
        lfsr      <= lfsr_step(lfsr);
        if (rw_both || misaligned) protocol_error <= 1'b1;
        if (bus.read && !bus.write) rdata_p1 <= mem[idx];
      end
      if (drop) protocol_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.write && !bus.read) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

endmodule
